// File: rtl/id_stage_if.sv
// Bundle of the ID stage's data path: IF/ID side inputs, write-back port,
// EX-stage instruction for hazard detection, and everything that feeds ID/EX.
// The stage itself uses the slave modport; whoever drives the stage uses master.
interface id_stage_if;
    logic [15:0] pc_in;
    logic [15:0] instruction_in;
    logic [15:0] ex_instruction;
    logic        wb_load_regfile;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_load_cc;
    logic        stall_in;

    logic [15:0] pc_out;
    logic [15:0] instruction_out;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic        br_enable;
    logic        idex_load;
    logic        ifid_load;
    logic [15:0] stall_count;

    modport slave (
        input  pc_in, instruction_in, ex_instruction,
        input  wb_load_regfile, wb_dest, wb_data, wb_load_cc, stall_in,
        output pc_out, instruction_out, sr1_out, sr2_out,
        output br_enable, idex_load, ifid_load, stall_count
    );

    modport master (
        output pc_in, instruction_in, ex_instruction,
        output wb_load_regfile, wb_dest, wb_data, wb_load_cc, stall_in,
        input  pc_out, instruction_out, sr1_out, sr2_out,
        input  br_enable, idex_load, ifid_load, stall_count
    );
endinterface

// File: rtl/id_stage.sv
// LC-3b instruction-decode stage: register file, NZP register, operand read,
// branch-enable, load-use hazard detection and bubble injection.
// Optional feature macro ID_WB_BYPASS_EN: forward the write-back value and the
// write-back NZP into this cycle's reads. Without it, a read of a register (or
// a conditional branch) racing a write-back is resolved with one bubble.
module id_stage (
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_SHF = 4'b1101;

    // Register file, one 16-bit register per generate instance, packed for reads
    logic [7:0][15:0] regs_q;
    logic [2:0]       nzp_reg;
    logic [15:0]      stall_count_reg;

    logic [2:0]  wb_nzp;
    logic [2:0]  nzp_eff;
    logic [3:0]  opcode;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        is_store;
    logic        sr1_used;
    logic        sr2_used;
    logic        ex_is_load;
    logic [2:0]  ex_dest;
    logic        load_use;
    logic        hazard;
    logic        bubble;
    logic [15:0] sr1_val;
    logic [15:0] sr2_val;

    // The low bits of the EX instruction carry nothing relevant to hazards
    logic unused_ex_bits;
    assign unused_ex_bits = ^bus.ex_instruction[8:0];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [15:0] data_reg;
            // Register gi: cleared by reset, loaded by a matching write-back
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (bus.wb_load_regfile && (bus.wb_dest == 3'(gi))) begin
                    data_reg <= bus.wb_data;
                end
            end
            assign regs_q[gi] = data_reg;
        end
    endgenerate

    // Condition codes derived from the write-back value (exactly one bit set)
    always_comb begin
        wb_nzp = 3'b001;
        if (bus.wb_data[15]) begin
            wb_nzp = 3'b100;
        end else if (bus.wb_data == 16'h0000) begin
            wb_nzp = 3'b010;
        end
    end

    // NZP register: reset to "zero", updated from write-back when requested
    always_ff @(posedge clk) begin
        if (reset) begin
            nzp_reg <= 3'b010;
        end else if (bus.wb_load_cc) begin
            nzp_reg <= wb_nzp;
        end
    end

    // Source field selection and which fields the opcode really reads
    always_comb begin
        opcode   = bus.instruction_in[15:12];
        is_store = (opcode == OP_STB) || (opcode == OP_STR) || (opcode == OP_STI);
        sr1      = bus.instruction_in[8:6];
        sr2      = is_store ? bus.instruction_in[11:9] : bus.instruction_in[2:0];
        sr1_used = 1'b0;
        sr2_used = is_store;
        case (opcode)
            OP_ADD, OP_AND: begin
                sr1_used = 1'b1;
                sr2_used = !bus.instruction_in[5];
            end
            OP_NOT, OP_SHF, OP_JMP, OP_LDB, OP_LDI, OP_LDR,
            OP_STB, OP_STI, OP_STR: sr1_used = 1'b1;
            OP_JSR:  sr1_used = !bus.instruction_in[11];
            default: sr1_used = 1'b0;
        endcase
    end

    // Load in EX whose destination feeds a source read here
    always_comb begin
        ex_is_load = (bus.ex_instruction[15:12] == OP_LDB) ||
                     (bus.ex_instruction[15:12] == OP_LDI) ||
                     (bus.ex_instruction[15:12] == OP_LDR);
        ex_dest    = bus.ex_instruction[11:9];
        load_use   = ex_is_load && ((sr1_used && (ex_dest == sr1)) ||
                                    (sr2_used && (ex_dest == sr2)));
    end

`ifdef ID_WB_BYPASS_EN
    // Forward the in-flight write-back so no extra stall is needed
    always_comb begin
        sr1_val = regs_q[sr1];
        sr2_val = regs_q[sr2];
        if (bus.wb_load_regfile && (bus.wb_dest == sr1)) begin
            sr1_val = bus.wb_data;
        end
        if (bus.wb_load_regfile && (bus.wb_dest == sr2)) begin
            sr2_val = bus.wb_data;
        end
        nzp_eff = bus.wb_load_cc ? wb_nzp : nzp_reg;
        hazard  = load_use;
    end
`else
    // No forwarding: a read racing a write-back waits one bubble instead
    always_comb begin
        sr1_val = regs_q[sr1];
        sr2_val = regs_q[sr2];
        nzp_eff = nzp_reg;
        hazard  = load_use;
        if (bus.wb_load_regfile && ((sr1_used && (bus.wb_dest == sr1)) ||
                                    (sr2_used && (bus.wb_dest == sr2)))) begin
            hazard = 1'b1;
        end
        if (bus.wb_load_cc && (opcode == OP_BR) &&
            (bus.instruction_in[11:9] != 3'b000)) begin
            hazard = 1'b1;
        end
    end
`endif

    // A global stall wins: nothing advances and no bubble is inserted
    assign bubble = hazard && !bus.stall_in;

    // Saturating count of injected bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (bubble && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    // Outputs toward ID/EX and the stall controls
    always_comb begin
        bus.pc_out          = bus.pc_in;
        bus.instruction_out = bubble ? 16'h0000 : bus.instruction_in;
        bus.sr1_out         = sr1_val;
        bus.sr2_out         = sr2_val;
        bus.br_enable       = !bubble && (opcode == OP_BR) &&
                              ((bus.instruction_in[11:9] & nzp_eff) != 3'b000);
        bus.idex_load       = !bus.stall_in;
        bus.ifid_load       = !bus.stall_in && !hazard;
        bus.stall_count     = stall_count_reg;
    end
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_id_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Opcode sets indexed by opcode value
    localparam logic [15:0] SR1_OPS   = 16'h3EEE; // ADD AND NOT SHF JMP LDB LDI LDR STB STI STR
    localparam logic [15:0] STORE_OPS = 16'h0888; // STB STR STI
    localparam logic [15:0] LOAD_OPS  = 16'h0444; // LDB LDR LDI

    // Reference state
    logic [15:0] m_regs [8];
    logic [2:0]  m_nzp;
    logic [15:0] m_cnt;
    bit          m_valid = 1'b0;

    function automatic logic [2:0] cc_of(logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] read_reg(logic [2:0] r);
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_load_regfile && bus.wb_dest == r) return bus.wb_data;
`endif
        return m_regs[r];
    endfunction

    // What the stage must present for the current inputs and model state
    task automatic model_outputs(output logic [15:0] e_instr, output logic [15:0] e_sr1,
                                 output logic [15:0] e_sr2, output logic e_br,
                                 output logic e_idex, output logic e_ifid, output logic e_bubble);
        logic [15:0] ir;
        logic [3:0]  op;
        logic [3:0]  exop;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  nzp_use;
        logic [2:0]  srcs[$];
        logic        haz;
        ir   = bus.instruction_in;
        op   = ir[15:12];
        exop = bus.ex_instruction[15:12];
        s1   = ir[8:6];
        s2   = STORE_OPS[op] ? ir[11:9] : ir[2:0];
        if (SR1_OPS[op] || (op == 4'd4 && !ir[11])) srcs.push_back(s1);
        if (STORE_OPS[op] || ((op == 4'd1 || op == 4'd5) && !ir[5])) srcs.push_back(s2);
        haz = 1'b0;
        foreach (srcs[i]) begin
            if (LOAD_OPS[exop] && bus.ex_instruction[11:9] == srcs[i]) haz = 1'b1;
`ifndef ID_WB_BYPASS_EN
            if (bus.wb_load_regfile && bus.wb_dest == srcs[i]) haz = 1'b1;
`endif
        end
        nzp_use = m_nzp;
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_load_cc) nzp_use = cc_of(bus.wb_data);
`else
        if (bus.wb_load_cc && op == 4'd0 && ir[11:9] != 3'd0) haz = 1'b1;
`endif
        e_bubble = haz && !bus.stall_in;
        e_instr  = e_bubble ? 16'h0000 : ir;
        e_sr1    = read_reg(s1);
        e_sr2    = read_reg(s2);
        e_br     = !e_bubble && op == 4'd0 && ((ir[11:9] & nzp_use) != 3'd0);
        e_idex   = !bus.stall_in;
        e_ifid   = !bus.stall_in && !haz;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state update at each edge, from pre-edge inputs
    always @(posedge clk) begin
        logic [15:0] ei, e1, e2;
        logic eb, ed, ef, ebub;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_nzp   = 3'b010;
            m_cnt   = 16'h0000;
            m_valid = 1'b1;
        end else if (m_valid) begin
            model_outputs(ei, e1, e2, eb, ed, ef, ebub);
            if (bus.wb_load_regfile) m_regs[bus.wb_dest] = bus.wb_data;
            if (bus.wb_load_cc) m_nzp = cc_of(bus.wb_data);
            if (ebub && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [15:0] ei, e1, e2;
        logic eb, ed, ef, ebub;
        if (!reset && m_valid) begin
            model_outputs(ei, e1, e2, eb, ed, ef, ebub);
            chk("pc_out", bus.pc_out, bus.pc_in);
            chk("instruction_out", bus.instruction_out, ei);
            chk("sr1_out", bus.sr1_out, e1);
            chk("sr2_out", bus.sr2_out, e2);
            chk("br_enable", 16'(bus.br_enable), 16'(eb));
            chk("idex_load", 16'(bus.idex_load), 16'(ed));
            chk("ifid_load", 16'(bus.ifid_load), 16'(ef));
            chk("stall_count", bus.stall_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wb_load_regfile = 1'b0;
        bus.wb_load_cc      = 1'b0;
        bus.wb_dest         = 3'd0;
        bus.wb_data         = 16'h0000;
        bus.stall_in        = 1'b0;
        bus.ex_instruction  = 16'h0000;
    endtask

    initial begin
        reset = 1'b1;
        bus.pc_in = 16'h3000;
        bus.instruction_in = 16'h0000;
        idle_inputs();
        repeat (2) tick();
        reset = 1'b0;
        settle();
        chk("rst_sr1", bus.sr1_out, 16'h0000);
        chk("rst_br", 16'(bus.br_enable), 16'd0);
        chk("rst_idex", 16'(bus.idex_load), 16'd1);
        chk("rst_ifid", 16'(bus.ifid_load), 16'd1);

        // Write R3, read it, then reset must wipe it
        tick();
        bus.wb_load_regfile = 1'b1; bus.wb_dest = 3'd3; bus.wb_data = 16'h1234;
        tick();
        idle_inputs();
        bus.instruction_in = 16'h12C0;          // ADD R1,R3,R0
        settle();
        chk("r3_written", bus.sr1_out, 16'h1234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("r3_after_reset", bus.sr1_out, 16'h0000);
        chk("cnt_after_reset", bus.stall_count, 16'h0000);
        tick();
        bus.instruction_in = 16'h0400;          // BRz: NZP is 010 after reset
        settle();
        chk("brz_after_reset", 16'(bus.br_enable), 16'd1);
        tick();
        bus.instruction_in = 16'h0A00;          // BRnp
        settle();
        chk("brnp_after_reset", 16'(bus.br_enable), 16'd0);

        // R5 = 8001 with CC update, then read and branch on it
        tick();
        bus.instruction_in = 16'h0000;
        bus.wb_load_regfile = 1'b1; bus.wb_dest = 3'd5; bus.wb_data = 16'h8001; bus.wb_load_cc = 1'b1;
        tick();
        idle_inputs();
        bus.instruction_in = 16'h1342;          // ADD R1,R5,R2
        settle();
        chk("r5_read", bus.sr1_out, 16'h8001);
        tick();
        bus.instruction_in = 16'h0800;          // BRn
        settle();
        chk("brn_taken", 16'(bus.br_enable), 16'd1);
        tick();
        bus.instruction_in = 16'h0600;          // BRzp
        settle();
        chk("brzp_not_taken", 16'(bus.br_enable), 16'd0);

        // Load-use: LDR R2 in EX, ADD R1,R2,R3 in ID
        tick();
        bus.ex_instruction = 16'h6400;
        bus.instruction_in = 16'h1283;
        settle();
        chk("lu_ifid", 16'(bus.ifid_load), 16'd0);
        chk("lu_instr", bus.instruction_out, 16'h0000);
        chk("lu_br", 16'(bus.br_enable), 16'd0);
        tick();
        bus.ex_instruction = 16'h0000;          // bubble moved into EX
        settle();
        chk("lu_issue_ifid", 16'(bus.ifid_load), 16'd1);
        chk("lu_issue_instr", bus.instruction_out, 16'h1283);
        chk("lu_count", bus.stall_count, 16'd1);

        // Store data source comes from ir[11:9]
        tick();
        bus.ex_instruction = 16'h6800;          // LDR R4,R0,#0
        bus.instruction_in = 16'h7840;          // STR R4,R1,#0
        settle();
        chk("str_hazard", 16'(bus.ifid_load), 16'd0);
        tick();
        bus.instruction_in = 16'h12A4;          // ADD R1,R2,#4: imm field is not a source
        settle();
        chk("imm_no_hazard", 16'(bus.ifid_load), 16'd1);

        // Global stall beats the hazard
        tick();
        bus.ex_instruction = 16'h6400;
        bus.instruction_in = 16'h1283;
        bus.stall_in = 1'b1;
        settle();
        chk("st_idex", 16'(bus.idex_load), 16'd0);
        chk("st_ifid", 16'(bus.ifid_load), 16'd0);
        chk("st_instr", bus.instruction_out, 16'h1283);
        tick();
        settle();
        chk("st_count_frozen", bus.stall_count, 16'd2);
        tick();
        bus.stall_in = 1'b0;
        settle();
        chk("st_bubble_after", bus.instruction_out, 16'h0000);
        tick();
        bus.ex_instruction = 16'h0000;
        settle();
        chk("st_count_after", bus.stall_count, 16'd3);

        // Same-cycle write-back of R6 with ID reading R6
        tick();
        bus.instruction_in = 16'h1380;          // ADD R1,R6,R0
        bus.wb_load_regfile = 1'b1; bus.wb_dest = 3'd6; bus.wb_data = 16'h00FF;
        settle();
`ifdef ID_WB_BYPASS_EN
        chk("byp_sr1", bus.sr1_out, 16'h00FF);
        chk("byp_ifid", 16'(bus.ifid_load), 16'd1);
`else
        chk("nobyp_ifid", 16'(bus.ifid_load), 16'd0);
        chk("nobyp_instr", bus.instruction_out, 16'h0000);
`endif
        tick();
        idle_inputs();
        settle();
        chk("wb_r6_sr1", bus.sr1_out, 16'h00FF);
        chk("wb_r6_ifid", 16'(bus.ifid_load), 16'd1);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            tick();
            bus.pc_in          = 16'($urandom);
            bus.instruction_in = 16'($urandom);
            if ($urandom_range(1, 0) == 1)
                bus.ex_instruction = {LOAD_OPS_PICK($urandom_range(2, 0)), 12'($urandom)};
            else
                bus.ex_instruction = 16'($urandom);
            bus.wb_load_regfile = ($urandom_range(2, 0) == 0);
            bus.wb_dest         = 3'($urandom);
            case ($urandom_range(3, 0))
                0: bus.wb_data = 16'h0000;
                1: bus.wb_data = 16'h8000 | 16'($urandom);
                default: bus.wb_data = 16'($urandom);
            endcase
            bus.wb_load_cc = ($urandom_range(3, 0) == 0);
            bus.stall_in   = ($urandom_range(7, 0) == 0);
        end
        tick();
        idle_inputs();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [3:0] LOAD_OPS_PICK(int unsigned k);
        case (k)
            0: return 4'b0010;
            1: return 4'b0110;
            default: return 4'b1010;
        endcase
    endfunction
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage LC-3b pipeline, sitting between the IF/ID latch and the ID/EX latch. It holds the eight-entry 16-bit register file and the NZP condition-code register, and reads the source operands. It computes the branch-enable bit and detects load-use hazards, stalling fetch and injecting a NOP bubble into ID/EX when needed. All outputs feeding ID/EX are combinational; the control ROM downstream is driven from `instruction_out`.

## Interface
- No parameters; widths fixed by `lc3b_types` (`lc3b_word` = 16 bits).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the rising edge where it is high.
- `pc_in` in 16: PC from IF/ID.
- `instruction_in` in 16: instruction from IF/ID.
- `ex_instruction` in 16: instruction currently in EX, i.e. the ID/EX latch's instruction output.
- `wb_load_regfile` in 1: write-back register write enable.
- `wb_dest` in 3: write-back destination register.
- `wb_data` in 16: write-back data.
- `wb_load_cc` in 1: update NZP from `wb_data`.
- `stall_in` in 1: global pipeline stall from memory.
- `pc_out` out 16: equals `pc_in`.
- `instruction_out` out 16: `instruction_in`, or 16'h0000 when bubbling.
- `sr1_out` out 16: regfile[sr1 field].
- `sr2_out` out 16: regfile[sr2 field].
- `br_enable` out 1: branch condition met.
- `idex_load` out 1: load enable for ID/EX.
- `ifid_load` out 1: load enable for IF/ID and the PC.
- `stall_count` out 16: saturating count of hazard-stall cycles.

## Operation
- **Source selection**
  - sr1 = ir[8:6].
  - sr2 = ir[11:9] for STR (0111), STB (0011) and STI (1011); ir[2:0] otherwise.
- **Source usage (hazard purposes only)**
  - sr1 is used by ADD, AND, NOT, SHF, JMP, LDB, LDI, LDR, STB, STI, STR, and by JSRR (opcode 0100 with ir[11]=0).
  - sr2 is used by ADD or AND with ir[5]=0, and by all stores.
  - All other opcodes use no sources.
- **Register file**
  - 8×16.
  - Written at the rising edge when `wb_load_regfile`=1.
  - Reads are combinational.
- **CC register**
  - 3 bits {n,z,p}.
  - On `wb_load_cc`=1 it takes n=`wb_data[15]`, z=(`wb_data`==0), p=otherwise.
  - Exactly one bit is set after any update.
- **br_enable**
  - Equals |(ir[11:9] & NZP) when opcode=0000; 0 for every other opcode and during a bubble.
- **Load-use hazard**
  - Asserted when `ex_instruction` opcode ∈ {LDB 0010, LDI 1010, LDR 0110} and its ir[11:9] equals a used source register of `instruction_in`.
- **Stall arbitration**
  - `idex_load` = !`stall_in`.
  - `ifid_load` = !`stall_in` & !hazard.
  - bubble = hazard & !`stall_in`.
  - `stall_in` dominates: no bubble is injected and nothing advances.
- **Bubble**
  - `instruction_out`=16'h0000 (BR with nzp=000, i.e. NOP) and `br_enable`=0.
  - `pc_out`, `sr1_out` and `sr2_out` pass through unchanged.
- **stall_count**
  - Increments by 1 each cycle bubble=1.
  - Saturates at 16'hFFFF.

## Timing
- **Reset**
  - All 8 registers = 16'h0000.
  - NZP = 3'b010.
  - `stall_count` = 0.
  - Reset has priority over a simultaneous WB write or CC update.
- **Combinational outputs**
  - Purely combinational from current inputs and state.
  - With IF/ID holding 16'h0000 after reset: `sr1_out`=`sr2_out`=0, `br_enable`=0, `idex_load`=1, `ifid_load`=1.
- **Hazard latency**
  - A load-use hazard costs exactly one bubble cycle.
  - On the next edge the load moves to MEM, the hazard clears, and the dependent instruction issues.
- **Register write timing**
  - A WB write becomes visible to reads in the cycle after the edge that writes it, unless bypassed (see Configuration).
- **Continuous stall**
  - With `stall_in` held high, all state except WB-driven regfile/CC writes is frozen, and `stall_count` does not change.

## Configuration
- **`ID_WB_BYPASS_EN` defined**
  - Reading the register that is being written this cycle (`wb_load_regfile`=1 and `wb_dest` matches) returns `wb_data`.
  - `br_enable` uses the NZP computed from `wb_data` when `wb_load_cc`=1.
  - No extra stalls.
- **`ID_WB_BYPASS_EN` undefined**
  - Reads return the stored value.
  - The hazard condition additionally asserts when `wb_load_regfile`=1 and `wb_dest` equals a used source.
  - The hazard condition also asserts when `wb_load_cc`=1 and the ID instruction is a BR with nzp≠000.
  - Each such case costs one bubble cycle, counted in `stall_count`.

## Test plan
- **Reset:** write R3=16'h1234, then assert `reset` for one edge → R3 reads 0, NZP=010, `stall_count`=0.
- **Write/read and CC:**
  - WB R5=16'h8001 with `wb_load_cc`=1, then ID holds ADD R1,R5,R2 → `sr1_out`=16'h8001 next cycle.
  - Then BRn in ID → `br_enable`=1.
  - Then BRzp → `br_enable`=0.
- **Load-use:** EX=LDR R2,R0,#0, ID=ADD R1,R2,R3 → one cycle with `ifid_load`=0, `instruction_out`=0, `br_enable`=0; next cycle normal issue; `stall_count`=1.
- **Store source:** EX=LDR R4, ID=STR R4,R1,#0 → hazard via the ir[11:9] source. ID=ADD R1,R2,#4 with EX=LDR R4 → no hazard.
- **Global stall precedence:** `stall_in`=1 during a load-use hazard → `idex_load`=0, `ifid_load`=0, no bubble, `stall_count` unchanged; bubble occurs after `stall_in` drops.
- **Bypass (both builds):** same-cycle WB R6=16'h00FF with ID reading R6 → bypass build: `sr1_out`=16'h00FF, no stall; non-bypass build: one bubble, then `sr1_out`=16'h00FF.
